// File: rtl/datapath_ctrl.sv
// Sequencing controller for the 4-entry register-file/ALU datapath: accepts packed micro-instructions
// and runs each through EXEC/WB. Define CTRL_REPEAT_EN to enable the repeat-count field.
module datapath_ctrl #(
  parameter int REP_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REP_W+9:0] instr,
  input  logic             instr_valid,
  output logic             instr_ready,
  output logic             wr,
  output logic [1:0]       addr1,
  output logic [1:0]       addr2,
  output logic [1:0]       addr3,
  output logic [2:0]       ALUControl,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic       r_we;
  logic       r_done;
  logic [1:0] r_a1;
  logic [1:0] r_a2;
  logic [1:0] r_a3;
  logic [2:0] r_op;
  logic       w_accept;
  logic       w_last;

  // Handshake: a transfer happens on a rising edge where instr_valid and instr_ready are both 1;
  // instr_ready is 1 only in IDLE, and instr is ignored everywhere else.
  assign w_accept = (r_state == IDLE) && instr_valid;

`ifdef CTRL_REPEAT_EN
  logic [REP_W-1:0] r_cnt;

  assign w_last = (r_cnt == '0);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (w_accept) begin
      r_cnt <= instr[REP_W+9:10];
    end else if ((r_state == WB) && !w_last) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end
`else
  logic w_unused_rep;

  assign w_unused_rep = ^instr[REP_W+9:10];
  assign w_last       = 1'b1;
`endif

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (instr_valid) w_next = EXEC;
      EXEC:    w_next = WB;
      WB:      w_next = w_last ? IDLE : EXEC;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
      r_we    <= 1'b0;
      r_done  <= 1'b0;
      r_a1    <= 2'd0;
      r_a2    <= 2'd0;
      r_a3    <= 2'd0;
      r_op    <= 3'd0;
    end else begin
      r_state <= w_next;
      r_done  <= (r_state == WB) && w_last;
      // Controls are loaded only on accept so they stay put through every iteration and in IDLE.
      if (w_accept) begin
        r_we <= instr[9];
        r_op <= instr[8:6];
        r_a3 <= instr[5:4];
        r_a1 <= instr[3:2];
        r_a2 <= instr[1:0];
      end
    end
  end

  assign instr_ready = (r_state == IDLE);
  assign busy        = (r_state != IDLE);
  assign wr          = (r_state == WB) && r_we;
  assign done        = r_done;
  assign addr1       = r_a1;
  assign addr2       = r_a2;
  assign addr3       = r_a3;
  assign ALUControl  = r_op;

endmodule

// File: tb/tb_datapath_ctrl.sv
// Bench for datapath_ctrl: drives micro-instructions into the controller, which steers a small
// register-file/ALU model; a reference model predicts every write and done event and their cycles.
`timescale 1ns/1ps
module tb_datapath_ctrl;
  localparam int REP_W  = 4;
  localparam int IW     = REP_W + 10;
  localparam int EW     = 34;
  localparam int N_RAND = 40;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [IW-1:0] instr       = '0;
  logic          instr_valid = 1'b0;
  logic          instr_ready, wr, busy, done;
  logic [1:0]    addr1, addr2, addr3;
  logic [2:0]    ALUControl;

  datapath_ctrl #(.REP_W(REP_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .instr      (instr),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .wr         (wr),
    .addr1      (addr1),
    .addr2      (addr2),
    .addr3      (addr3),
    .ALUControl (ALUControl),
    .busy       (busy),
    .done       (done)
  );

  // ---------------- datapath model driven by the controller ----------------
  function automatic logic [7:0] alu(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    case (op)
      3'd0:    return a & b;
      3'd1:    return a | b;
      3'd2:    return a + b;
      3'd3:    return a ^ b;
      3'd4:    return a & ~b;
      3'd5:    return a | ~b;
      3'd6:    return a - b;
      default: return (a < b) ? 8'd1 : 8'd0;
    endcase
  endfunction

  logic [7:0] dp_rf [4];
  logic       pl_en   = 1'b0;
  logic [1:0] pl_addr = '0;
  logic [7:0] pl_data = '0;
  logic [7:0] dp_res;
  assign dp_res = alu(dp_rf[addr1], dp_rf[addr2], ALUControl);

  always @(posedge clk) begin
    if (pl_en) dp_rf[pl_addr] <= pl_data;
    else if (wr) dp_rf[addr3] <= dp_res;
  end

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q[$];
  logic [7:0]    ref_rf   [4];
  logic [7:0]    ref_save [4];
  int checks = 0, failures = 0;
  int win_lo = 0, win_hi = 0;
  int wr_cnt = 0, done_cnt = 0;
  bit mon_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [EW-1:0] pack(input int c, input logic k, input logic [1:0] a3,
                                          input logic [1:0] a1, input logic [1:0] a2,
                                          input logic [2:0] op, input logic [7:0] d);
    logic [31:0] cc;
    cc = c;
    return {cc[15:0], k, a3, a1, a2, op, d};
  endfunction

  function automatic logic [IW-1:0] mk(input int rep, input bit we, input int op, input int dst,
                                       input int a, input int b);
    logic [31:0] r, o, d, x, y;
    r = rep; o = op; d = dst; x = a; y = b;
    return {r[REP_W-1:0], we, o[2:0], d[1:0], x[1:0], y[1:0]};
  endfunction

  function automatic int iters(input logic [IW-1:0] ins);
`ifdef CTRL_REPEAT_EN
    return int'(ins[IW-1:10]) + 1;
`else
    return 1;
`endif
  endfunction

  // Reference: n iterations of rf[dst] = op(rf[a], rf[b]); write k lands at t0+2k+1, done at t0+2n.
  task automatic push_expect(input logic [IW-1:0] ins, input int t0);
    int n;
    logic [7:0] v;
    n = iters(ins);
    for (int i = 0; i < n; i++) begin
      if (ins[9]) begin
        v = alu(ref_rf[ins[3:2]], ref_rf[ins[1:0]], ins[8:6]);
        exp_q.push_back(pack(t0 + 2*i + 1, 1'b0, ins[5:4], ins[3:2], ins[1:0], ins[8:6], v));
        ref_rf[ins[5:4]] = v;
      end
    end
    exp_q.push_back(pack(t0 + 2*n, 1'b1, ins[5:4], ins[3:2], ins[1:0], ins[8:6], 8'd0));
    win_lo = t0;
    win_hi = t0 + 2*n;
  endtask

  // ---------------- monitor ----------------
  logic          mon_busy;
  logic [EW-1:0] mon_got, mon_exp;
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        mon_busy = (cyc >= win_lo) && (cyc < win_hi);
        check("busy", busy, mon_busy);
        check("instr_ready", instr_ready, !mon_busy);
        if (wr) wr_cnt++;
        if (done) done_cnt++;
        if (wr || done) begin
          mon_got = pack(cyc, done, addr3, addr1, addr2, ALUControl, done ? 8'd0 : dp_res);
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_event: wr=%0b done=%0b got %0h with nothing expected (cycle %0d)",
                     wr, done, mon_got, cyc);
          end else begin
            mon_exp = exp_q.pop_front();
            check("event", mon_got, mon_exp);
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic preload(input int a, input logic [7:0] d);
    pl_en = 1'b1; pl_addr = a[1:0]; pl_data = d;
    @(negedge clk);
    pl_en = 1'b0;
    ref_rf[a[1:0]] = d;
  endtask

  task automatic issue(input logic [IW-1:0] ins, input bit keep, output int t0, output int waited);
    instr = ins; instr_valid = 1'b1; waited = 0;
    while (!instr_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (!instr_ready) begin
      checks++; failures++;
      $display("FAIL accept_timeout: instr_ready got 0 expected 1 after %0d cycles", waited);
      instr_valid = 1'b0;
      t0 = -1;
      return;
    end
    t0 = cyc + 1;
    ref_save = ref_rf;
    push_expect(ins, t0);
    @(negedge clk);
    if (!keep) begin
      instr_valid = 1'b0;
      instr = IW'($urandom);
    end
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    while (cyc < win_hi && g < 200) begin
      @(negedge clk);
      g++;
    end
    if (cyc < win_hi) begin
      checks++; failures++;
      $display("FAIL idle_timeout: cycle got %0d expected at least %0d", cyc, win_hi);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time got %0t expected completion earlier", $time);
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    int t0, t1, w, wr0, dn0, k;
    logic [IW-1:0] ins;
    logic [7:0] va, vb;

    // Reset held two edges while a request is offered.
    rst = 1'b0; instr_valid = 1'b1; instr = mk(0, 1, 2, 3, 1, 2);
    @(negedge clk); @(negedge clk);
    check("rst_wr", wr, 0);
    check("rst_addr", {addr1, addr2, addr3}, 0);
    check("rst_alu", ALUControl, 0);
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
    instr_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    check("post_rst_ready", instr_ready, 1);
    check("post_rst_busy", busy, 0);
    mon_en = 1'b1;
    for (int i = 0; i < 4; i++) preload(i, 8'($urandom));

    // Single operation.
    va = 8'($urandom); vb = 8'($urandom);
    preload(1, va); preload(2, vb);
    issue(mk(0, 1, 2, 3, 1, 2), 1'b0, t0, w);
    check("exec_addr1", addr1, 1);
    check("exec_addr2", addr2, 2);
    check("exec_addr3", addr3, 3);
    check("exec_alu", ALUControl, 2);
    check("exec_wr", wr, 0);
    @(negedge clk);
    check("wb_wr", wr, 1);
    wait_idle();
    check("single_r3", dp_rf[3], va + vb);

    // Repeat accumulation into r1.
    preload(1, 8'd0); preload(2, 8'd5);
    issue(mk(3, 1, 2, 1, 1, 2), 1'b0, t0, w);
    wait_idle();
`ifdef CTRL_REPEAT_EN
    check("repeat_r1", dp_rf[1], 20);
`else
    check("repeat_r1", dp_rf[1], 5);
`endif

    // No-write sequence.
    issue(mk(1, 0, $urandom_range(0, 7), $urandom_range(0, 3), $urandom_range(0, 3),
             $urandom_range(0, 3)), 1'b0, t0, w);
    wr0 = wr_cnt; dn0 = done_cnt;
    wait_idle();
    @(negedge clk); #1;
    check("nowrite_wr_count", wr_cnt - wr0, 0);
    check("nowrite_done_count", done_cnt - dn0, 1);

    // Maximum repeat count.
    issue(mk((1 << REP_W) - 1, 1, 2, 0, 0, 3), 1'b0, t0, w);
    wait_idle();

    // Valid held with changing instr while busy; the next is taken one cycle after done.
    issue(mk($urandom_range(0, 2), 1, $urandom_range(0, 7), $urandom_range(0, 3),
             $urandom_range(0, 3), $urandom_range(0, 3)), 1'b1, t0, w);
    k = 0;
    while (!instr_ready && k < 100) begin
      instr = IW'($urandom);
      @(negedge clk);
      k++;
    end
    t1 = win_hi;
    issue(IW'($urandom), 1'b0, t0, w);
    check("b2b_accept_cycle", t0, t1 + 1);
    wait_idle();

    // Idle with valid low: nothing moves.
    repeat (5) begin
      instr = IW'($urandom);
      @(negedge clk);
    end
    check("idle_no_accept", busy, 0);

    // Reset during the 3rd write-back (only write-back when repeats are disabled).
`ifdef CTRL_REPEAT_EN
    k = 2;
`else
    k = 0;
`endif
    ins = mk(5, 1, 2, 0, 0, 1);
    issue(ins, 1'b0, t0, w);
    while (cyc < t0 + 2*k + 1) @(negedge clk);
    #2 rst = 1'b0;
    @(posedge clk); #1;
    exp_q.delete();
    ref_rf = ref_save;
    for (int i = 0; i <= k; i++) ref_rf[0] = alu(ref_rf[0], ref_rf[1], 3'd2);
    win_hi = cyc;
    @(negedge clk);
    check("midrst_wr", wr, 0);
    check("midrst_done", done, 0);
    check("midrst_addr", {addr1, addr2, addr3, ALUControl}, 0);
    rst = 1'b1;
    issue(mk(1, 1, 6, 2, 0, 1), 1'b0, t0, w);
    check("midrst_immediate_accept", w, 0);
    wait_idle();
    check("midrst_r0", dp_rf[0], ref_rf[0]);

    // Randomized traffic with random gaps.
    for (int n = 0; n < N_RAND; n++) begin
      repeat ($urandom_range(0, 3)) begin
        instr = IW'($urandom);
        @(negedge clk);
      end
      issue(IW'($urandom), 1'b0, t0, w);
    end
    wait_idle();
    @(negedge clk);

    check("queue_empty", exp_q.size(), 0);
    for (int i = 0; i < 4; i++) check("final_rf", dp_rf[i], ref_rf[i]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
